// File: rtl/controle_registrador_rr.sv
// rtl/controle_registrador_rr.sv - round-robin access controller for a shared register
//
// Arbitrates N_REQ requesters issuing load/clear/increment/read operations on
// an external WIDTH-bit register that loads its D input on every Clk edge.
// Transaction flow is IDLE -> WRITE -> ACK -> IDLE, one transaction per 3 cycles.
//
// Ports:
//   Clk      in   system clock, rising edge
//   Reset    in   asynchronous active-high reset (also wired to the register)
//   req      in   per-requester request, level, held until ack
//   op       in   2 bits per requester: 00 load, 01 clear, 10 increment, 11 read
//   data     in   WIDTH bits per requester, load data
//   gnt      out  one-hot grant, high in WRITE and ACK
//   ack      out  one-cycle completion pulse to the granted requester
//   rd_data  out  register value after the completed operation
//   busy     out  high whenever the FSM is not IDLE
//   reg_d    out  register D input
//   reg_q    in   register Q output (feedback)
//
// Build option: ARB_FIXED_PRIO_EN selects fixed priority (lowest index wins)
// instead of round-robin.

module controle_registrador_rr #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [2*N_REQ-1:0]     op,
  input  logic [WIDTH*N_REQ-1:0] data,
  output logic [N_REQ-1:0]       gnt,
  output logic [N_REQ-1:0]       ack,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   busy,
  output logic [WIDTH-1:0]       reg_d,
  input  logic [WIDTH-1:0]       reg_q
);

  localparam int IDXW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_ACK   = 2'd2;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_CLEAR = 2'd1;
  localparam logic [1:0] OP_INC   = 2'd2;
  localparam logic [1:0] OP_READ  = 2'd3;

  logic [1:0]       r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_data;
  logic [WIDTH-1:0] r_rd_data;
`ifndef ARB_FIXED_PRIO_EN
  logic [IDXW-1:0]  r_last;
  int               w_idx;
`endif

  logic             w_found;
  logic [IDXW-1:0]  w_win;
  logic [1:0]       w_op;
  logic [WIDTH-1:0] w_data;
  logic [N_REQ-1:0] w_onehot;

  // Winner selection
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
`ifdef ARB_FIXED_PRIO_EN
    // Scan downward so the lowest set index is the last (and final) assignment.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        w_found = 1'b1;
        w_win   = IDXW'(k);
      end
    end
`else
    // Search upward starting just after the previous winner, wrapping around.
    w_idx = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(r_last) + k;
      if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
      if (!w_found && req[IDXW'(w_idx)]) begin
        w_found = 1'b1;
        w_win   = IDXW'(w_idx);
      end
    end
`endif
  end

  // Payload mux of the winning requester
  always_comb begin
    w_op   = '0;
    w_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (w_win == IDXW'(k)) begin
        w_op   = op[2*k +: 2];
        w_data = data[WIDTH*k +: WIDTH];
      end
    end
  end

  assign w_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_gnt     <= '0;
      r_op      <= '0;
      r_data    <= '0;
      r_rd_data <= '0;
`ifndef ARB_FIXED_PRIO_EN
      r_last    <= IDXW'(N_REQ - 1);
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_op    <= w_op;
            r_data  <= w_data;
            r_gnt   <= w_onehot;
`ifndef ARB_FIXED_PRIO_EN
            r_last  <= w_win;
`endif
            r_state <= S_WRITE;
          end
        end
        S_WRITE: begin
          r_state <= S_ACK;
        end
        S_ACK: begin
          // reg_q already holds the value captured at the end of WRITE.
          r_rd_data <= reg_q;
          r_gnt     <= '0;
          r_state   <= S_IDLE;
        end
        default: begin
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Register D input: feedback hold except during WRITE.
  always_comb begin
    reg_d = reg_q;
    if (r_state == S_WRITE) begin
      case (r_op)
        OP_LOAD:  reg_d = r_data;
        OP_CLEAR: reg_d = '0;
        OP_INC:   reg_d = reg_q + WIDTH'(1);
        OP_READ:  reg_d = reg_q;
        default:  reg_d = reg_q;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign ack     = (r_state == S_ACK) ? r_gnt : '0;
  assign busy    = (r_state != S_IDLE);
  // Bypass so rd_data is already valid while ack is high.
  assign rd_data = (r_state == S_ACK) ? reg_q : r_rd_data;

endmodule

// File: doc/controle_registrador_rr.md
Name: controle_registrador_rr

Overview:
- Round-robin access controller for the shared 8-bit register (bank of D flip-flops, loads every Clk edge, no enable).
- Arbitrates N_REQ requesters issuing load/clear/increment/read operations and drives the register D input; holds the value by feedback when idle.
- Sits between the requesting units and the register instance; the register's S output feeds back as reg_q.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- WIDTH, 8, register data width.

Ports:
- Clk  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset; also wired to the register.
- req  input  N_REQ  request per requester; level, held until ack.
- op  input  2*N_REQ  op of requester i at [2i+1:2i]: 00 load, 01 clear, 10 increment, 11 read.
- data  input  WIDTH*N_REQ  load data of requester i at [WIDTH*i+WIDTH-1:WIDTH*i].
- gnt  output  N_REQ  one-hot grant, high in WRITE and ACK states.
- ack  output  N_REQ  one-cycle completion pulse to the granted requester.
- rd_data  output  WIDTH  register value after the completed operation; valid with ack.
- busy  output  1  high whenever state is not IDLE.
- reg_d  output  WIDTH  to register D input.
- reg_q  input  WIDTH  from register Q output.

Behaviour:
- Reset (async, Reset=1): state=IDLE, gnt=0, ack=0, busy=0, rd_data=0, op/data latches=0, last_winner=N_REQ-1 (requester 0 wins first). Register clears to 0 via the same Reset.
- reg_d is combinational:
  - IDLE and ACK: reg_d=reg_q (hold).
  - WRITE, by latched op: load -> latched data; clear -> 0; increment -> reg_q+1 modulo 2^WIDTH (0xFF -> 0x00, no carry out); read -> reg_q.
- FSM IDLE -> WRITE -> ACK -> IDLE. No waiting states.
- IDLE:
  - If any req bit is set, at the Clk edge pick the winner: first set bit searching upward from last_winner+1, wrapping.
  - At that edge: latch winner op/data, set gnt one-hot, update last_winner, go to WRITE.
  - With no req, stay in IDLE.
- WRITE (1 cycle): reg_d carries the new value; the register captures it at the end of the cycle. Go to ACK.
- ACK (1 cycle): ack[winner]=1, rd_data<=reg_q (the new value) registered at the ACK-exit edge and held until the next ACK; gnt stays set. Go to IDLE.
- Fixed latency: req sampled at edge t -> WRITE at t+1, register updated at t+2, ack high during t+2..t+3, rd_data valid from t+3 (and during ack via bypass: rd_data output = reg_q while in ACK).
- Throughput: one transaction per 3 cycles.
- A requester holding req after ack counts as a new request next IDLE, subject to rotation.
- req deasserted after grant: the transaction completes from the latched op/data and ack still pulses.
- req or op/data changes during WRITE/ACK are ignored.
- Simultaneous requests: exactly one gnt bit set. Never more than one ack bit set.
- Reset mid-transaction: abort immediately, no ack, register=0, state=IDLE.

Optional Feature:
- Macro ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; last_winner is unused. Starvation of high indices is accepted.
- Undefined (default): round-robin as above.

Test Plan:
- Reset then req[0]=1, op=00, data=0xA5 -> gnt=0001 in 2 cycles, ack[0] one cycle, reg_q=0xA5, rd_data=0xA5, busy low after.
- Register at 0xFF; req[2] op=10 -> reg_q=0x00 at ack, rd_data=0x00 (wrap).
- req=1111 held continuously, all op=11 -> grant order 0,1,2,3,0, each ack separated by 3 cycles. With ARB_FIXED_PRIO_EN -> only requester 0 is served.
- Register 0x3C; req[1] op=01 then req[3] op=11 -> reg_q=0x00, requester 3 rd_data=0x00.
- req[1] load 0x77 and Reset pulsed during WRITE -> no ack, reg_q=0x00, gnt=0, state IDLE; next request is served normally.
- Idle 10 cycles with register=0x5A, no req -> reg_d=0x5A every cycle, value unchanged, ack=0.
